// File: rtl/multi_channel_serializer.sv
// Round-robin arbiter over NUM_CHANNELS wide FWFT inputs, serialized as [channel id header, data beats LSB-first].
// Define SERDES_PARITY_EN to append an XOR-of-data-beats parity beat to each frame.
module multi_channel_serializer #(
    parameter int HUB_FIFO_WIDTH          = 32,
    parameter int HUB_FIFO_PHYSICAL_WIDTH = 4,
    parameter int NUM_CHANNELS            = 4,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS*HUB_FIFO_WIDTH-1:0] wide_fifo_data,
    input  logic [NUM_CHANNELS-1:0]                wide_fifo_valid,
    output logic [NUM_CHANNELS-1:0]                wide_fifo_ready,
    output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]     narrow_fifo_data,
    output logic                                   narrow_fifo_valid,
    input  logic                                   narrow_fifo_ready,
    output logic                                   busy,
    output logic [CH_W-1:0]                        active_channel
);

    localparam int W     = HUB_FIFO_WIDTH;
    localparam int P     = HUB_FIFO_PHYSICAL_WIDTH;
    localparam int BEATS = W / P;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
`ifdef SERDES_PARITY_EN
        DATA   = 2'd2,
        PARITY = 2'd3
`else
        DATA   = 2'd2
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] grant;
    logic            grant_vld;
    logic            capture;
    logic            hs;
    logic            last_beat;
    logic [W-1:0]    shift_reg;
    logic [W-1:0]    shifted;
    logic [BCW-1:0]  beat_cnt;
    logic [P-1:0]    hdr_beat;
`ifdef SERDES_PARITY_EN
    logic [P-1:0]    parity_acc;
`endif

    assign hs        = narrow_fifo_valid && narrow_fifo_ready;
    assign last_beat = (beat_cnt == BCW'(BEATS - 1));
    assign shifted   = shift_reg >> P;
    assign busy      = (state != IDLE);
    // Reset also gates the read strobe so no word is consumed while held in reset.
    assign capture   = (state == IDLE) && grant_vld && !reset;

    // Search upward from rr_ptr; iterating downward lets the nearest valid channel win.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (wide_fifo_valid[idx]) begin
                grant     = CH_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        hdr_beat             = '0;
        hdr_beat[CH_W-1:0]   = grant;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (capture) state_nxt = HEADER;
            HEADER: if (hs) state_nxt = DATA;
`ifdef SERDES_PARITY_EN
            DATA:   if (hs && last_beat) state_nxt = PARITY;
            PARITY: if (hs) state_nxt = IDLE;
`else
            DATA:   if (hs && last_beat) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wide_fifo_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wide_fifo_ready[c] = capture && (int'(grant) == c);
        end
    end

    // Beat registers only advance on a handshake, so a stalled beat stays put.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            narrow_fifo_valid <= 1'b0;
            narrow_fifo_data  <= '0;
            active_channel    <= '0;
            rr_ptr            <= '0;
            shift_reg         <= '0;
            beat_cnt          <= '0;
`ifdef SERDES_PARITY_EN
            parity_acc        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        shift_reg         <= wide_fifo_data[int'(grant)*W +: W];
                        active_channel    <= grant;
                        rr_ptr            <= (int'(grant) == NUM_CHANNELS - 1) ? '0 : grant + 1'b1;
                        narrow_fifo_valid <= 1'b1;
                        narrow_fifo_data  <= hdr_beat;
                        beat_cnt          <= '0;
`ifdef SERDES_PARITY_EN
                        parity_acc        <= '0;
`endif
                    end
                end
                HEADER: begin
                    if (hs) begin
                        narrow_fifo_data <= shift_reg[P-1:0];
                        beat_cnt         <= '0;
                    end
                end
                DATA: begin
                    if (hs) begin
                        shift_reg <= shifted;
                        beat_cnt  <= beat_cnt + 1'b1;
`ifdef SERDES_PARITY_EN
                        parity_acc <= parity_acc ^ narrow_fifo_data;
                        if (last_beat) narrow_fifo_data <= parity_acc ^ narrow_fifo_data;
                        else           narrow_fifo_data <= shifted[P-1:0];
`else
                        if (last_beat) narrow_fifo_valid <= 1'b0;
                        else           narrow_fifo_data  <= shifted[P-1:0];
`endif
                    end
                end
`ifdef SERDES_PARITY_EN
                PARITY: begin
                    if (hs) narrow_fifo_valid <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
